// File: rtl/lsu_axi_master_if.sv
// lsu_axi_master_if: AXI-lite channel bundle between the LSU (master) and dsram (slave).
//  Read address : araddr, arvalid, arready
//  Read data    : rdata, rresp, rvalid, rready
//  Write address: awaddr, awvalid, awready
//  Write data   : wdata, wstrb, wvalid, wready
//  Write resp   : bresp, bvalid, bready
interface lsu_axi_master_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [ADDR_W-1:0]   araddr, awaddr;
   logic [DATA_W-1:0]   rdata, wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic [1:0]          rresp, bresp;
   logic                arvalid, arready, rvalid, rready;
   logic                awvalid, awready, wvalid, wready, bvalid, bready;
   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/lsu_axi_master.sv
// lsu_axi_master: runs one LSU load/store request as a single AXI-lite transaction.
//  clk, rst_n            clock, asynchronous active-low reset
//  req_*                 request from EX (valid/ready, we, addr, wdata, size, unsigned)
//  rsp_*                 response to WB (valid/ready, rdata, err)
//  axi                   AXI-lite master channels (lsu_axi_master_if.master)
//  LSU_MISALIGN_TRAP_EN  when defined, misaligned half/word requests trap without bus access
module lsu_axi_master #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   lsu_axi_master_if.master  axi
);
   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WADDR, WRESP, RSP} state_t;
   state_t            st, nxt;
   logic [1:0]        off, size;
   logic              uns, aw_done, w_done, mis, hs;
   logic [7:0]        lb;
   logic [15:0]       lh;
   logic [DATA_W-1:0] ld;
   assign hs = req_valid & req_ready;
`ifdef LSU_MISALIGN_TRAP_EN
   assign mis = req_size == 2'b01 ? req_addr[0] : req_size[1] & |req_addr[1:0];
`else
   assign mis = 1'b0;
`endif
   // lane extraction from the latched offset; size 11 behaves as word via size[1]
   assign lb = axi.rdata[{off, 3'b000} +: 8];
   assign lh = axi.rdata[{off[1], 4'b0000} +: 16];
   assign ld = size[1] ? axi.rdata :
               size[0] ? {{(DATA_W-16){lh[15] & ~uns}}, lh} : {{(DATA_W-8){lb[7] & ~uns}}, lb};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) st <= IDLE;
      else        st <= nxt;
   always_comb begin
      nxt         = st;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      axi.arvalid = 1'b0;
      axi.rready  = 1'b0;
      axi.awvalid = 1'b0;
      axi.wvalid  = 1'b0;
      axi.bready  = 1'b0;
      case (st)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) nxt = mis ? RSP : req_we ? WADDR : RADDR;
         end
         RADDR: begin
            axi.arvalid = 1'b1;
            if (axi.arready) nxt = RDATA;
         end
         RDATA: begin
            axi.rready = 1'b1;
            if (axi.rvalid) nxt = RSP;
         end
         WADDR: begin
            axi.awvalid = ~aw_done;
            axi.wvalid  = ~w_done;
            if ((aw_done | axi.awready) & (w_done | axi.wready)) nxt = WRESP;
         end
         WRESP: begin
            axi.bready = 1'b1;
            if (axi.bvalid) nxt = RSP;
         end
         RSP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         off        <= '0;
         size       <= '0;
         uns        <= 1'b0;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
         axi.araddr <= '0;
         axi.awaddr <= '0;
         axi.wdata  <= '0;
         axi.wstrb  <= '0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
      end else begin
         // done flags remember a channel accepted earlier while the other still waits
         aw_done <= st == WADDR && nxt == WADDR && (aw_done || axi.awready);
         w_done  <= st == WADDR && nxt == WADDR && (w_done || axi.wready);
         if (hs) begin
            off       <= req_addr[1:0];
            size      <= req_size;
            uns       <= req_unsigned;
            rsp_rdata <= '0;
            rsp_err   <= mis;
            if (!mis && !req_we) axi.araddr <= {req_addr[ADDR_W-1:2], 2'b00};
            if (!mis && req_we) begin
               axi.awaddr <= {req_addr[ADDR_W-1:2], 2'b00};
               axi.wstrb  <= req_size[1] ? 4'b1111 :
                             req_size[0] ? 4'b0011 << {req_addr[1], 1'b0} : 4'b0001 << req_addr[1:0];
               axi.wdata  <= req_size[1] ? req_wdata :
                             req_size[0] ? {2{req_wdata[15:0]}} : {4{req_wdata[7:0]}};
            end
         end
         if (st == RDATA && axi.rvalid) begin
            rsp_rdata <= ld;
            rsp_err   <= |axi.rresp;
         end
         if (st == WRESP && axi.bvalid) rsp_err <= |axi.bresp;
      end
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: scoreboard bench for lsu_axi_master with a randomly stalling AXI-lite slave.
module tb_lsu_axi_master;
`ifdef LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif
   typedef struct packed {logic [31:0] d; logic e;} rsp_t;
   typedef struct packed {logic [31:0] a; logic [3:0] s; logic [31:0] d;} wr_t;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;
   rsp_t        rq[$];
   wr_t         wq[$];
   logic [31:0] aq[$];
   logic [31:0] smem[16], mmem[16];
   int          nv = 0, nerr = 0, rsp_hold = 0;
   bit          rnd = 1'b0, hold_b = 1'b0;
   logic [1:0]  rresp_inj = '0, bresp_inj = '0;
   always #5 clk = ~clk;
   lsu_axi_master_if axi();
   lsu_axi_master dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .axi(axi)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nv++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic cyc;
      @(posedge clk);
      #1;
   endtask
   function automatic int dly;
      return rnd ? $urandom_range(0, 3) : 0;
   endfunction
   function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
      return TRAP && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
   endfunction
   function automatic logic [31:0] ldm(input logic [31:0] w, input logic [31:0] a,
                                       input logic [1:0] sz, input logic u);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*a[1:0] +: 8];
      h = a[1] ? w[31:16] : w[15:0];
      if (sz == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
      if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
      return w;
   endfunction
   task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic u);
      rsp_t        e;
      logic [3:0]  s;
      logic [31:0] d;
      int          k = 0;
      req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = u; req_valid = 1'b1;
      while (!req_ready && k < 300) begin
         cyc;
         k++;
      end
      if (!req_ready) begin
         chk("req_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      if (misal(sz, a)) e = '{32'h0, 1'b1};
      else if (we) begin
         s = sz[1] ? 4'hF : sz[0] ? (a[1] ? 4'hC : 4'h3) : 4'h1 << a[1:0];
         d = sz[1] ? wd : sz[0] ? {wd[15:0], wd[15:0]} : {4{wd[7:0]}};
         wq.push_back('{a & ~32'h3, s, d});
         for (int i = 0; i < 4; i++) if (s[i]) mmem[a[5:2]][8*i +: 8] = d[8*i +: 8];
         e = '{32'h0, bresp_inj != 2'b00};
      end else begin
         aq.push_back(a & ~32'h3);
         e = '{ldm(mmem[a[5:2]], a, sz, u), rresp_inj != 2'b00};
      end
      rq.push_back(e);
      cyc;
      req_valid = 1'b0;
   endtask
   task automatic drain;
      int k = 0;
      while ((rq.size() != 0 || !req_ready) && k < 500) begin
         cyc;
         k++;
      end
      if (k >= 500) chk("drain_timeout", 32'd0, 32'd1);
   endtask
   initial begin : s_ar
      logic [31:0] a;
      forever begin
         cyc;
         if (axi.arvalid) begin
            a = axi.araddr;
            if (aq.size() == 0) chk("ar_spurious", 32'd1, 32'd0);
            else chk("araddr", a, aq.pop_front());
            repeat (dly()) begin
               cyc;
               chk("ar_hold", axi.araddr, a);
            end
            axi.arready = 1'b1;
            cyc;
            axi.arready = 1'b0;
            repeat (dly()) begin
               cyc;
               chk("ar_hold_r", axi.araddr, a);
            end
            axi.rvalid = 1'b1;
            axi.rdata  = smem[a[5:2]];
            axi.rresp  = rresp_inj;
            cyc;
            axi.rvalid = 1'b0;
         end
      end
   end
   initial begin : s_w
      logic [31:0] aa, dd;
      logic [3:0]  ss;
      wr_t         w;
      forever begin
         cyc;
         if (axi.awvalid || axi.wvalid) begin
            if ($urandom_range(0, 2) == 0) begin
               repeat (dly()) cyc;
               axi.awready = 1'b1;
               aa = axi.awaddr;
               cyc;
               axi.awready = 1'b0;
               repeat (dly()) cyc;
               axi.wready = 1'b1;
               dd = axi.wdata;
               ss = axi.wstrb;
               cyc;
               axi.wready = 1'b0;
            end else if ($urandom_range(0, 1) == 0) begin
               repeat (dly()) cyc;
               axi.wready = 1'b1;
               dd = axi.wdata;
               ss = axi.wstrb;
               cyc;
               axi.wready = 1'b0;
               repeat (dly()) cyc;
               axi.awready = 1'b1;
               aa = axi.awaddr;
               cyc;
               axi.awready = 1'b0;
            end else begin
               repeat (dly()) cyc;
               axi.awready = 1'b1;
               axi.wready  = 1'b1;
               aa = axi.awaddr;
               dd = axi.wdata;
               ss = axi.wstrb;
               cyc;
               axi.awready = 1'b0;
               axi.wready  = 1'b0;
            end
            if (wq.size() == 0) chk("aw_spurious", 32'd1, 32'd0);
            else begin
               w = wq.pop_front();
               chk("awaddr", aa, w.a);
               chk("wstrb", {28'h0, ss}, {28'h0, w.s});
               chk("wdata", dd, w.d);
            end
            for (int i = 0; i < 4; i++) if (ss[i]) smem[aa[5:2]][8*i +: 8] = dd[8*i +: 8];
            repeat (dly()) begin
               cyc;
               chk("aw_hold", axi.awaddr, aa);
               chk("w_hold", axi.wdata, dd);
            end
            while (hold_b) cyc;
            axi.bvalid = 1'b1;
            axi.bresp  = bresp_inj;
            cyc;
            axi.bvalid = 1'b0;
         end
      end
   end
   initial begin : s_rsp
      rsp_t e;
      forever begin
         cyc;
         if (rsp_valid) begin
            if (rq.size() == 0) chk("rsp_spurious", 32'd1, 32'd0);
            else begin
               e = rq.pop_front();
               repeat (rsp_hold) begin
                  chk("rsp_hold", rsp_rdata, e.d);
                  chk("req_ready_stall", {31'h0, req_ready}, 32'd0);
                  cyc;
               end
               chk("rsp_rdata", rsp_rdata, e.d);
               chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.e});
            end
            rsp_ready = 1'b1;
            cyc;
            rsp_ready = 1'b0;
            chk("rsp_drop", {31'h0, rsp_valid}, 32'd0);
         end
      end
   end
   initial begin : watchdog
      #2000000;
      chk("global_timeout", 32'd0, 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
      $finish;
   end
   initial begin : main
      int k;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = '0;
      for (int i = 0; i < 16; i++) smem[i] = $urandom;
      smem[0] = 32'h8001_1234;
      mmem = smem;
      repeat (3) cyc;
      chk("rst_req_ready", {31'h0, req_ready}, 32'd1);
      chk("rst_valids", {26'h0, rsp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 32'd0);
      chk("rst_rdata", rsp_rdata, 32'd0);
      chk("rst_araddr", axi.araddr, 32'd0);
      chk("rst_wstrb", {28'h0, axi.wstrb}, 32'd0);
      rst_n = 1'b1;
      cyc;
      do_req(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b0);
      chk("lat_ar", {31'h0, axi.arvalid}, 32'd1);
      cyc;
      chk("lat_n2", {31'h0, rsp_valid}, 32'd0);
      cyc;
      chk("lat_n3", {31'h0, rsp_valid}, 32'd1);
      drain;
      do_req(1'b0, 32'h8000_0002, 32'h0, 2'b01, 1'b1); drain;
      do_req(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'b10, 1'b0); drain;
      do_req(1'b1, 32'h8000_0003, 32'h0000_00A5, 2'b00, 1'b0); drain;
      do_req(1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b0); drain;
      do_req(1'b0, 32'h8000_0003, 32'h0, 2'b00, 1'b1); drain;
      do_req(1'b0, 32'h8000_0001, 32'h0, 2'b10, 1'b0);
      chk("trap_rsp", {31'h0, rsp_valid}, {31'h0, TRAP});
      chk("trap_ar", {31'h0, axi.arvalid}, {31'h0, ~TRAP});
      drain;
      do_req(1'b1, 32'h8000_0007, 32'h1234_CAFE, 2'b01, 1'b0); drain;
      do_req(1'b0, 32'h8000_0004, 32'h0, 2'b11, 1'b0); drain;
      rresp_inj = 2'b10;
      do_req(1'b0, 32'h8000_0008, 32'h0, 2'b10, 1'b0); drain;
      rresp_inj = 2'b00;
      do_req(1'b0, 32'h8000_0008, 32'h0, 2'b10, 1'b0); drain;
      bresp_inj = 2'b11;
      do_req(1'b1, 32'h8000_0010, 32'h0102_0304, 2'b10, 1'b0); drain;
      bresp_inj = 2'b00;
      rnd = 1'b1;
      rsp_hold = 5;
      for (int i = 0; i < 40; i++) begin
         if (i == 8) rsp_hold = 1;
         do_req(1'($urandom_range(0, 1)), 32'h8000_0000 | ($urandom & 32'h3F), $urandom,
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      drain;
      rnd = 1'b0;
      rsp_hold = 0;
      hold_b = 1'b1;
      do_req(1'b1, 32'h8000_000C, 32'h55AA_55AA, 2'b10, 1'b0);
      k = 0;
      while (!axi.bready && k < 50) begin
         cyc;
         k++;
      end
      chk("wresp_reached", {31'h0, axi.bready}, 32'd1);
      cyc;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valids", {26'h0, rsp_valid, axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 32'd0);
      chk("rst_mid_awaddr", axi.awaddr, 32'd0);
      void'(rq.pop_back());
      cyc;
      rst_n = 1'b1;
      repeat (5) begin
         cyc;
         chk("rst_no_rsp", {31'h0, rsp_valid}, 32'd0);
      end
      do_req(1'b0, 32'h8000_000C, 32'h0, 2'b10, 1'b0); drain;
      $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
      $finish;
   end
endmodule
